// File: rtl/src_rate_engine_if.sv
// Streaming + rate-config bundle for the SRC rate engine.
// master = upstream/config driver and downstream sink; slave = the engine.
interface src_rate_engine_if #(
  parameter int DATA_W = 16
);
  logic [2:0]        int_rate;
  logic              int_valid;
  logic [2:0]        dec_rate;
  logic              dec_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              cfg_err;
  logic              busy;

  modport master (
    output int_rate, int_valid, dec_rate, dec_valid, s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, cfg_err, busy
  );

  modport slave (
    input  int_rate, int_valid, dec_rate, dec_valid, s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, cfg_err, busy
  );
endinterface

// File: rtl/src_rate_engine.sv
// Rational-rate converter: zero-stuffs each sample by L, keeps every M-th phase.
// Latency 1 cycle accept->m_valid; stalls all state while the output slot is full.
module src_rate_engine #(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  src_rate_engine_if.slave    bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [2:0]        l_q, l_d, m_q, m_d;
  logic [2:0]        pend_l_q, pend_l_d, pend_m_q, pend_m_d;
  logic              cfg_pend_q, cfg_pend_d;
  logic              cfg_seen_q, cfg_seen_d;
  logic              cfg_err_q, cfg_err_d;
  logic [2:0]        phase_q, phase_d;
  logic [2:0]        dec_cnt_q, dec_cnt_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              run_en_q;

  logic              cfg_v, cfg_edge, slot_free, s_ready, accept, do_emit;
  logic [DATA_W-1:0] emit_val;

  always_comb begin
    state_d    = state_q;
    l_d        = l_q;
    m_d        = m_q;
    pend_l_d   = pend_l_q;
    pend_m_d   = pend_m_q;
    cfg_pend_d = cfg_pend_q;
    cfg_err_d  = 1'b0;
    phase_d    = phase_q;
    dec_cnt_d  = dec_cnt_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    do_emit    = 1'b0;
    emit_val   = '0;

    cfg_v      = bus.int_valid & bus.dec_valid;
    cfg_edge   = cfg_v & ~cfg_seen_q;
    cfg_seen_d = cfg_v;
    slot_free  = ~m_valid_q | bus.m_ready;
    // run_en_q keeps s_ready low until the first edge after reset release
    s_ready    = run_en_q & (state_q == IDLE) & slot_free & ~cfg_pend_q;
    accept     = bus.s_valid & s_ready;

    case (state_q)
      IDLE: begin
        if (cfg_pend_q) begin
          l_d        = pend_l_q;
          m_d        = pend_m_q;
          dec_cnt_d  = '0;
          cfg_pend_d = 1'b0;
          if (bus.m_ready) m_valid_d = 1'b0;
        end else if (accept) begin
          do_emit  = 1'b1;
          emit_val = bus.s_data;
          if (l_q > 3'd1) begin
            phase_d = 3'd1;
            state_d = RUN;
          end
        end else if (bus.m_ready) begin
          m_valid_d = 1'b0;
        end
      end
      default: begin
        if (slot_free) begin
          do_emit = 1'b1;
          if (phase_q == l_q - 3'd1) begin
            phase_d = '0;
            state_d = IDLE;
          end else begin
            phase_d = phase_q + 3'd1;
          end
        end
      end
    endcase

    // Emission only happens with a free slot, so a dropped phase can clear m_valid
    if (do_emit) begin
      if (dec_cnt_q == 3'd0) begin
        m_data_d  = emit_val;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
      dec_cnt_d = (dec_cnt_q == m_q - 3'd1) ? 3'd0 : dec_cnt_q + 3'd1;
    end

    // Capture after apply so a same-cycle edge re-arms the pending config
    if (cfg_edge) begin
      if (bus.int_rate == 3'd0 || bus.dec_rate == 3'd0) begin
        cfg_err_d = 1'b1;
      end else begin
        pend_l_d   = bus.int_rate;
        pend_m_d   = bus.dec_rate;
        cfg_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      l_q        <= 3'd1;
      m_q        <= 3'd1;
      pend_l_q   <= 3'd1;
      pend_m_q   <= 3'd1;
      cfg_pend_q <= 1'b0;
      cfg_seen_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      phase_q    <= '0;
      dec_cnt_q  <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      run_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      l_q        <= l_d;
      m_q        <= m_d;
      pend_l_q   <= pend_l_d;
      pend_m_q   <= pend_m_d;
      cfg_pend_q <= cfg_pend_d;
      cfg_seen_q <= cfg_seen_d;
      cfg_err_q  <= cfg_err_d;
      phase_q    <= phase_d;
      dec_cnt_q  <= dec_cnt_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      run_en_q   <= 1'b1;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_data  = m_data_q;
  assign bus.m_valid = m_valid_q;
  assign bus.cfg_err = cfg_err_q;
  assign bus.busy    = (state_q == RUN);
endmodule

// File: tb/tb_src_rate_engine.sv
// Directed bench for src_rate_engine: per-cycle vector table plus corner sequences.
module tb_src_rate_engine;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  src_rate_engine_if #(.DATA_W(DW)) bus();

  src_rate_engine #(.DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  typedef struct {
    logic          iv;
    logic [2:0]    ir;
    logic          dv;
    logic [2:0]    dr;
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic          e_srdy;
    logic          e_mvld;
    logic [DW-1:0] e_mdat;
    logic          e_busy;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   err_hi = 0;

  function automatic vec_t mk(input logic iv, input int ir, input logic dv, input int dr,
                              input logic sv, input int sd, input logic mr,
                              input logic srdy, input logic mvld, input int mdat,
                              input logic busy);
    vec_t v;
    v.iv = iv; v.ir = 3'(ir); v.dv = dv; v.dr = 3'(dr);
    v.sv = sv; v.sd = DW'(sd); v.mr = mr;
    v.e_srdy = srdy; v.e_mvld = mvld; v.e_mdat = DW'(mdat); v.e_busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs for one cycle at the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic iv, input int ir, input logic dv, input int dr,
                       input logic sv, input int sd, input logic mr);
    @(negedge clk);
    bus.int_valid = iv; bus.int_rate = 3'(ir);
    bus.dec_valid = dv; bus.dec_rate = 3'(dr);
    bus.s_valid   = sv; bus.s_data   = DW'(sd);
    bus.m_ready   = mr;
    #1;
  endtask

  task automatic obs(input string tag, input logic srdy, input logic mvld,
                     input int mdat, input logic busy);
    chk({tag, " s_ready"}, 32'(bus.s_ready), 32'(srdy));
    chk({tag, " m_valid"}, 32'(bus.m_valid), 32'(mvld));
    if (mvld) chk({tag, " m_data"}, 32'(bus.m_data), 32'(DW'(mdat)));
    chk({tag, " busy"}, 32'(bus.busy), 32'(busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.int_valid = 0; bus.int_rate = 0; bus.dec_valid = 0; bus.dec_rate = 0;
    bus.s_valid = 0; bus.s_data = 0; bus.m_ready = 0;

    // Cycle-accurate vectors: stream at 1/1, then L=3/M=1, L=1/M=3, L=3/M=2
    tbl.push_back(mk(0,0,0,0, 1, 1,1, 1,0, 0,0));
    tbl.push_back(mk(0,0,0,0, 1, 2,1, 1,1, 1,0));
    tbl.push_back(mk(0,0,0,0, 1, 3,1, 1,1, 2,0));
    tbl.push_back(mk(0,0,0,0, 0, 0,1, 1,1, 3,0));
    tbl.push_back(mk(0,0,0,0, 0, 0,1, 1,0, 0,0));
    tbl.push_back(mk(1,3,1,1, 0, 0,1, 1,0, 0,0));
    tbl.push_back(mk(1,3,1,1, 0, 0,1, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0, 1, 5,1, 1,0, 0,0));
    tbl.push_back(mk(0,0,0,0, 1, 7,1, 0,1, 5,1));
    tbl.push_back(mk(0,0,0,0, 1, 7,1, 0,1, 0,1));
    tbl.push_back(mk(0,0,0,0, 1, 7,1, 1,1, 0,0));
    tbl.push_back(mk(0,0,0,0, 0, 0,1, 0,1, 7,1));
    tbl.push_back(mk(0,0,0,0, 0, 0,1, 0,1, 0,1));
    tbl.push_back(mk(0,0,0,0, 0, 0,1, 1,1, 0,0));
    tbl.push_back(mk(1,1,1,3, 0, 0,1, 1,0, 0,0));
    tbl.push_back(mk(0,0,0,0, 0, 0,1, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0, 1,10,1, 1,0, 0,0));
    tbl.push_back(mk(0,0,0,0, 1,11,1, 1,1,10,0));
    tbl.push_back(mk(0,0,0,0, 1,12,1, 1,0, 0,0));
    tbl.push_back(mk(0,0,0,0, 1,13,1, 1,0, 0,0));
    tbl.push_back(mk(0,0,0,0, 1,14,1, 1,1,13,0));
    tbl.push_back(mk(0,0,0,0, 1,15,1, 1,0, 0,0));
    tbl.push_back(mk(0,0,0,0, 1,16,1, 1,0, 0,0));
    tbl.push_back(mk(0,0,0,0, 0, 0,1, 1,1,16,0));
    tbl.push_back(mk(1,3,1,2, 0, 0,1, 1,0, 0,0));
    tbl.push_back(mk(0,0,0,0, 0, 0,1, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0, 1, 4,1, 1,0, 0,0));
    tbl.push_back(mk(0,0,0,0, 1, 8,1, 0,1, 4,1));
    tbl.push_back(mk(0,0,0,0, 1, 8,1, 0,0, 0,1));
    tbl.push_back(mk(0,0,0,0, 1, 8,1, 1,1, 0,0));
    tbl.push_back(mk(0,0,0,0, 0, 0,1, 0,0, 0,1));
    tbl.push_back(mk(0,0,0,0, 0, 0,1, 0,1, 0,1));
    tbl.push_back(mk(0,0,0,0, 0, 0,1, 1,0, 0,0));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst m_data",  32'(bus.m_data),  32'd0);
    chk("rst s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst cfg_err", 32'(bus.cfg_err), 32'd0);
    chk("rst busy",    32'(bus.busy),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel s_ready", 32'(bus.s_ready), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, int'(tbl[i].ir), tbl[i].dv, int'(tbl[i].dr),
            tbl[i].sv, int'(tbl[i].sd), tbl[i].mr);
      obs($sformatf("v%0d", i), tbl[i].e_srdy, tbl[i].e_mvld, int'(tbl[i].e_mdat),
          tbl[i].e_busy);
      chk($sformatf("v%0d cfg_err", i), 32'(bus.cfg_err), 32'd0);
    end

    // Backpressure: L=2,M=1, stall four cycles on the first output
    drive(1,2,1,1, 0,0,1);
    drive(0,0,0,0, 0,0,1);
    drive(0,0,0,0, 1,9,1);  obs("bp acc", 1,0,0,0);
    for (int k = 0; k < 4; k++) begin
      drive(0,0,0,0, 1,21,0);
      obs($sformatf("bp hold%0d", k), 0,1,9,1);
    end
    drive(0,0,0,0, 1,21,1); obs("bp rel", 0,1,9,1);
    drive(0,0,0,0, 1,21,1); obs("bp ph1", 1,1,0,0);
    drive(0,0,0,0, 0,0,1);  obs("bp nxt", 0,1,21,1);
    drive(0,0,0,0, 0,0,1);  obs("bp ph1b", 1,1,0,0);
    drive(0,0,0,0, 0,0,1);  obs("bp drain", 1,0,0,0);

    // Zero rate: one-cycle cfg_err pulse, rates stay L=2,M=1
    err_hi = 0;
    drive(1,0,1,2, 0,0,1); if (bus.cfg_err) err_hi++;
    drive(1,0,1,2, 0,0,1); if (bus.cfg_err) err_hi++;
    drive(1,0,1,2, 0,0,1); if (bus.cfg_err) err_hi++;
    drive(0,0,0,0, 0,0,1); if (bus.cfg_err) err_hi++;
    chk("cfg_err width", 32'(err_hi), 32'd1);
    drive(0,0,0,0, 1,30,1); obs("err acc", 1,0,0,0);

    // L=4 edge during RUN applies only after the last phase
    drive(1,4,1,1, 0,0,1);  obs("mid cfg", 0,1,30,1);
    drive(1,4,1,1, 1,40,1); obs("apply", 0,1,0,0);
    drive(0,0,0,0, 1,40,1); obs("l4 acc", 1,0,0,0);
    drive(0,0,0,0, 0,0,1);  obs("l4 ph0", 0,1,40,1);
    drive(0,0,0,0, 0,0,1);  obs("l4 ph1", 0,1,0,1);
    drive(0,0,0,0, 0,0,1);  obs("l4 ph2", 0,1,0,1);
    drive(0,0,0,0, 1,50,1); obs("l4 ph3", 1,1,0,0);
    drive(0,0,0,0, 0,0,1);  obs("l4 run", 0,1,50,1);

    // Reset mid-RUN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst m_valid", 32'(bus.m_valid), 32'd0);
    chk("mrst busy",    32'(bus.busy),    32'd0);
    chk("mrst s_ready", 32'(bus.s_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0,0,0,0, 1,60,1); obs("post acc0", 1,0,0,0);
    drive(0,0,0,0, 1,61,1); obs("post acc1", 1,1,60,0);
    drive(0,0,0,0, 0,0,1);  obs("post out",  1,1,61,0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/src_rate_engine.md
Name: src_rate_engine

Overview:
- Downstream consumer of the SRC coefficient generator's int_rate/int_valid/dec_rate/dec_valid outputs.
- Captures interpolation factor L and decimation factor M, then converts a streaming sample flow by zero-stuffing by L and keeping every M-th phase.
- Sits between the ADC sample path and the anti-imaging/anti-alias FIR in the oscilloscope capture chain.
- Both sides use valid/ready streaming.

Parameters:
- DATA_W, 16: signed sample width on s_data and m_data.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- int_rate  in  3  interpolation factor L, legal values 1..7.
- int_valid  in  1  level qualifier for int_rate.
- dec_rate  in  3  decimation factor M, legal values 1..7.
- dec_valid  in  1  level qualifier for dec_rate.
- s_data  in  DATA_W  input sample.
- s_valid  in  1  input sample valid.
- s_ready  out  1  engine accepts s_data this cycle.
- m_data  out  DATA_W  output sample (registered).
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts m_data.
- cfg_err  out  1  one-cycle pulse: a rate of 0 was offered.
- busy  out  1  engine is emitting stuffed phases (state RUN).

Behaviour:
- Reset (rst low, asynchronous):
  - Outputs: m_data=0, m_valid=0, s_ready=0, cfg_err=0, busy=0.
  - Internal: L=1, M=1, phase=0, dec_cnt=0, cfg_pend=0, state=IDLE, cfg_seen_q=0.
  - Deassertion of rst takes effect synchronously.
- Config capture:
  - cfg_v = int_valid & dec_valid.
  - On a rising edge of cfg_v (cfg_v=1, cfg_seen_q=0):
    - If int_rate or dec_rate is 0: cfg_err=1 for one cycle; capture is discarded.
    - Otherwise: latch both rates into pend_L/pend_M and set cfg_pend=1.
  - Holding cfg_v high does not re-capture. A fresh edge while cfg_pend=1 overwrites pend_L/pend_M.
- Config apply:
  - Occurs in IDLE when cfg_pend=1: L<=pend_L, M<=pend_M, dec_cnt<=0, cfg_pend<=0.
  - s_ready=0 in that cycle, so no sample is accepted.
  - A config never applies mid-sample; while in RUN it waits for the return to IDLE.
- Definitions:
  - slot_free = !m_valid | m_ready.
  - emit(v): if dec_cnt==0, then m_data<=v and m_valid<=1. In all cases dec_cnt<=(dec_cnt==M-1)?0:dec_cnt+1.
  - If a phase is not kept and m_ready=1, m_valid<=0.
- State IDLE:
  - s_ready = slot_free & !cfg_pend.
  - On s_valid&s_ready: emit(s_data) as phase 0. If L>1, phase<=1 and go to RUN; else stay in IDLE.
  - With no accept and m_ready=1, m_valid<=0.
- State RUN (busy=1, s_ready=0):
  - Each cycle with slot_free: emit(0) for the current phase.
  - If phase==L-1: phase<=0 and go to IDLE; else phase<=phase+1.
  - With !slot_free: hold all state (backpressure stall).
- Latency and throughput:
  - Accepted sample to m_valid: 1 cycle.
  - L=M=1 sustains one sample per cycle with m_ready held high.
  - Steady-state output rate = L/M of the input rate.
- Ordering and counting:
  - Output preserves phase order.
  - dec_cnt runs continuously across sample boundaries; it is reset only by reset or a config apply.
- Holding:
  - m_data and m_valid are stable while m_valid=1 and m_ready=0.
- Simultaneous events:
  - cfg_v edge and s_valid in the same IDLE cycle: the sample is accepted if cfg_pend was 0 at the start of the cycle, and the config applies on the next IDLE cycle.
- Reset mid-RUN: the in-flight sample is discarded and rates return to 1/1.

Test Plan:
- Reset, no config; stream 1,2,3 with m_ready=1 → m_data 1,2,3 on consecutive cycles, 1-cycle latency, s_ready continuously 1.
- cfg edge L=3,M=1; input 5,7 → outputs 5,0,0,7,0,0; s_ready low during the two RUN cycles after each accept.
- cfg L=1,M=3; input 10,11,12,13,14,15,16 → outputs 10,13,16 only.
- cfg L=3,M=2; input 4,8 → phases 4,0,0,8,0,0; kept outputs 4,0,0.
- cfg L=2,M=1 then hold m_ready=0 for 4 cycles after the first output → m_data=9 held stable; after release, output 0 follows and the next sample is accepted only afterwards.
- Edge with int_rate=0 → cfg_err pulse for exactly 1 cycle, rates unchanged. Then a valid edge (L=4) during RUN → applied only after the current sample's last phase. Finally drive rst low mid-RUN → m_valid=0 immediately, next sample passes with L=M=1.
